// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Bundle of fetch, data and memory-port signals shared between
//             the pipeline requesters, the shared memory and the arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if;
  // Fetch requester (IF stage)
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_valid;
  logic [31:0] if_inst;
  // Data requester (MEM stage)
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  // Shared memory port
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata;
  // Pipeline freeze
  logic        stall_if;
  logic        stall_mem;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, if_flush, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
    output if_valid, if_inst, d_valid, d_rdata,
           mem_addr, mem_wdata, mem_rd, mem_wr, stall_if, stall_mem
  );

  // Requester / memory side
  modport master (
    output if_req, if_addr, if_flush, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
    input  if_valid, if_inst, d_valid, d_rdata,
           mem_addr, mem_wdata, mem_rd, mem_wr, stall_if, stall_mem
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Grants the single shared instruction/data memory port to the
//             IF or MEM stage, drives the command for MEM_LAT cycles and
//             returns a one-cycle completion pulse with the read data.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int MEM_LAT     = 1,  // 1..15
  parameter int MAX_DSTREAK = 4   // 1..15
) (
  input  wire logic         clock,
  input  wire logic         reset,
  mem_port_arbiter_if.slave bus_io
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  logic [1:0]  state_q,     state_d;
  logic        owner_q,     owner_d;
  logic [3:0]  lat_cnt_q,   lat_cnt_d;
  logic [3:0]  dstreak_q,   dstreak_d;
  logic        kill_q,      kill_d;
  logic        mem_rd_q,    mem_rd_d;
  logic        mem_wr_q,    mem_wr_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_valid_q,  if_valid_d;
  logic        d_valid_q,   d_valid_d;
  logic [31:0] if_inst_q,   if_inst_d;
  logic [31:0] d_rdata_q,   d_rdata_d;

  logic        if_req_ok;   // fetch request not cancelled by a same-cycle flush
  logic        d_req;
  logic        if_wins;

  // Arbitration decision: data by default, fetch when alone or starved
  always_comb begin
    if_req_ok = bus_io.if_req & ~bus_io.if_flush;
    d_req     = bus_io.d_rd | bus_io.d_wr;
    if_wins   = if_req_ok & (~d_req | (dstreak_q == STREAK_MAX));
  end

  // Next-state logic for the sequencer and all registered outputs
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    dstreak_d   = dstreak_q;
    kill_d      = kill_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_inst_d   = if_inst_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (!bus_io.if_req) begin
          dstreak_d = 4'd0;
        end
        if (d_req && !if_wins) begin
          // A simultaneous read+write is executed as a store only
          owner_d     = OWN_D;
          mem_addr_d  = bus_io.d_addr;
          mem_wdata_d = bus_io.d_wdata;
          mem_rd_d    = ~bus_io.d_wr;
          mem_wr_d    = bus_io.d_wr;
          lat_cnt_d   = LAT_INIT;
          state_d     = S_ACCESS;
          if (bus_io.if_req) begin
            dstreak_d = (dstreak_q >= STREAK_MAX) ? STREAK_MAX : dstreak_q + 4'd1;
          end
        end else if (if_req_ok) begin
          owner_d     = OWN_IF;
          mem_addr_d  = bus_io.if_addr;
          mem_wdata_d = 32'h0;
          mem_rd_d    = 1'b1;
          mem_wr_d    = 1'b0;
          lat_cnt_d   = LAT_INIT;
          state_d     = S_ACCESS;
          dstreak_d   = 4'd0;
        end
      end

      S_ACCESS: begin
        // A flush never aborts the memory command; it only hides the result
        if (owner_q == OWN_IF && bus_io.if_flush) begin
          kill_d = 1'b1;
        end
        if (lat_cnt_q == 4'd0) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          state_d  = S_DONE;
          if (owner_q == OWN_IF) begin
            if (!kill_q && !bus_io.if_flush) begin
              if_inst_d  = bus_io.mem_rdata;
              if_valid_d = 1'b1;
            end
          end else begin
            d_valid_d = 1'b1;
            if (!mem_wr_q) begin
              d_rdata_d = bus_io.mem_rdata;
            end
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        kill_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset discarding any in-flight access
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      lat_cnt_q   <= 4'd0;
      dstreak_q   <= 4'd0;
      kill_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_inst_q   <= 32'h0;
      d_rdata_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_cnt_q   <= lat_cnt_d;
      dstreak_q   <= dstreak_d;
      kill_q      <= kill_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_inst_q   <= if_inst_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus_io.mem_rd    = mem_rd_q;
  assign bus_io.mem_wr    = mem_wr_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_wdata = mem_wdata_q;
  assign bus_io.if_valid  = if_valid_q;
  assign bus_io.if_inst   = if_inst_q;
  assign bus_io.d_valid   = d_valid_q;
  assign bus_io.d_rdata   = d_rdata_q;

  // Stalls are combinational so the pipeline freezes in the request cycle
  assign bus_io.stall_if  = bus_io.if_req & ~if_valid_q;
  assign bus_io.stall_mem = (bus_io.d_rd | bus_io.d_wr) & ~d_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter: directed scenarios
//             followed by randomized fetch/load/store traffic checked every
//             cycle against a transaction-timestamp reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int L    = 3;
  localparam int MAXS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MEM_LAT(L), .MAX_DSTREAK(MAXS)) dut (
    .clock (clk),
    .reset (rst),
    .bus_io(bus)
  );

  // Shared memory: combinational read, write on the clock edge
  logic [31:0] memarr [0:1023];
  assign bus.mem_rdata = bus.mem_rd ? memarr[bus.mem_addr[11:2]] : 32'h0;
  always @(posedge clk) if (bus.mem_wr) memarr[bus.mem_addr[11:2]] = bus.mem_wdata;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: port owned for L+2 edges per grant ----
  int unsigned e = 0;        // edge counter
  int unsigned g = 0;        // edge of the current grant
  bit          busy = 1'b0;
  bit          own_d, op_wr, killed;
  logic [31:0] a;
  int          streak = 0;
  bit          m_ifok, m_dq, m_ifwin;
  logic        exp_mem_rd = 1'b0, exp_mem_wr = 1'b0, exp_ifv = 1'b0, exp_dv = 1'b0;
  logic [31:0] exp_maddr = '0, exp_mwdata = '0, exp_inst = '0, exp_rdata = '0;

  always @(posedge clk) begin
    e = e + 1;
    if (rst) begin
      busy = 1'b0; streak = 0;
      exp_mem_rd = 1'b0; exp_mem_wr = 1'b0; exp_ifv = 1'b0; exp_dv = 1'b0;
      exp_maddr = '0; exp_mwdata = '0; exp_inst = '0; exp_rdata = '0;
    end else begin
      exp_ifv = 1'b0;
      exp_dv  = 1'b0;
      if (!busy) begin
        m_ifok  = bus.if_req && !bus.if_flush;
        m_dq    = bus.d_rd || bus.d_wr;
        if (!bus.if_req) streak = 0;
        m_ifwin = m_ifok && (!m_dq || streak == MAXS);
        if (m_dq && !m_ifwin) begin
          busy = 1'b1; g = e; own_d = 1'b1; op_wr = bus.d_wr; killed = 1'b0;
          a = bus.d_addr;
          exp_maddr = bus.d_addr; exp_mwdata = bus.d_wdata;
          exp_mem_rd = !bus.d_wr; exp_mem_wr = bus.d_wr;
          if (bus.if_req) streak = (streak + 1 > MAXS) ? MAXS : streak + 1;
        end else if (m_ifok) begin
          busy = 1'b1; g = e; own_d = 1'b0; op_wr = 1'b0; killed = 1'b0;
          a = bus.if_addr;
          exp_maddr = bus.if_addr; exp_mwdata = 32'h0;
          exp_mem_rd = 1'b1; exp_mem_wr = 1'b0;
          streak = 0;
        end
      end else begin
        if (!own_d && bus.if_flush && e <= g + L) killed = 1'b1;
        if (e == g + L) begin
          exp_mem_rd = 1'b0; exp_mem_wr = 1'b0;
          if (own_d) begin
            exp_dv = 1'b1;
            if (!op_wr) exp_rdata = memarr[a[11:2]];
          end else if (!killed) begin
            exp_ifv = 1'b1;
            exp_inst = memarr[a[11:2]];
          end
        end
        if (e == g + L + 1) busy = 1'b0;
      end
    end
  end

  // ---------------- per-cycle comparison against the model ---------------
  always begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      chk("mem_rd",    {31'd0, bus.mem_rd},    {31'd0, exp_mem_rd});
      chk("mem_wr",    {31'd0, bus.mem_wr},    {31'd0, exp_mem_wr});
      chk("mem_addr",  bus.mem_addr,           exp_maddr);
      chk("mem_wdata", bus.mem_wdata,          exp_mwdata);
      chk("if_valid",  {31'd0, bus.if_valid},  {31'd0, exp_ifv});
      chk("d_valid",   {31'd0, bus.d_valid},   {31'd0, exp_dv});
      chk("if_inst",   bus.if_inst,            exp_inst);
      chk("d_rdata",   bus.d_rdata,            exp_rdata);
      chk("stall_if",  {31'd0, bus.stall_if},  {31'd0, bus.if_req & ~exp_ifv});
      chk("stall_mem", {31'd0, bus.stall_mem}, {31'd0, (bus.d_rd | bus.d_wr) & ~exp_dv});
    end
  end

  // Raise a fetch and measure negedges until if_valid (bounded)
  task automatic do_fetch(input logic [31:0] addr, output int cyc, output int rdc);
    bit got = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = addr;
    cyc = 0; rdc = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_rd) rdc++;
      if (bus.if_valid) got = 1'b1;
    end
    bus.if_req = 1'b0;
  endtask

  int          cyc, rdc, dcyc, icyc, n, nload, wcnt, vcnt, nvalid;
  logic [4:0]  ord;
  logic [31:0] dsave, rd_before;
  logic [31:0] r;

  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
    bus.d_rd = 0; bus.d_wr = 0; bus.d_addr = 0; bus.d_wdata = 0;
    for (int i = 0; i < 1024; i++) memarr[i] = $urandom;
    memarr[32'h40 >> 2]  = 32'h8C010004;
    memarr[32'h100 >> 2] = 32'hDEADBEEF;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_mem_rd",   {31'd0, bus.mem_rd},   32'd0);
    chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr,          32'd0);
    chk("rst_if_inst",  bus.if_inst,           32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch only
    do_fetch(32'h40, cyc, rdc);
    chk("fetch_latency", cyc, L + 1);
    chk("fetch_inst",    bus.if_inst, 32'h8C010004);
    chk("fetch_rd_cyc",  rdc, L);
    repeat (2) @(negedge clk);

    // Simultaneous fetch and load: data first, fetch one slot later
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    bus.d_rd = 1'b1; bus.d_addr = 32'h100;
    cyc = 0; dcyc = -100; icyc = -1; dsave = '0;
    for (int i = 0; i < 60 && icyc < 0; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.d_valid) begin dcyc = cyc; dsave = bus.d_rdata; bus.d_rd = 1'b0; end
      if (bus.if_valid) begin icyc = cyc; bus.if_req = 1'b0; end
    end
    bus.if_req = 1'b0; bus.d_rd = 1'b0;
    chk("sim_d_latency", dcyc, L + 1);
    chk("sim_d_rdata",   dsave, 32'hDEADBEEF);
    chk("sim_if_gap",    icyc - dcyc, L + 2);
    repeat (2) @(negedge clk);

    // Starvation: fetch held, four back-to-back loads
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    bus.d_rd = 1'b1; bus.d_addr = 32'h104;
    n = 0; nload = 0; ord = '0;
    for (int i = 0; i < 200 && n < 5; i++) begin
      @(negedge clk);
      if (bus.d_valid) begin
        ord[n] = 1'b0; n++; nload++;
        if (nload < 4) bus.d_addr = bus.d_addr + 32'd4;
        else bus.d_rd = 1'b0;
      end
      if (bus.if_valid) begin
        ord[n] = 1'b1; n++;
        bus.if_req = 1'b0;
        chk("starve_streak_clr", {28'd0, dut.dstreak_q}, 32'd0);
      end
    end
    bus.if_req = 1'b0; bus.d_rd = 1'b0;
    chk("starve_count", n, 5);
    chk("starve_order", {27'd0, ord}, 32'b00100);
    repeat (2) @(negedge clk);

    // Store: three write cycles, one pulse, load data untouched
    rd_before = bus.d_rdata;
    bus.d_wr = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678;
    wcnt = 0; vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.mem_wr && bus.mem_addr == 32'h200 && bus.mem_wdata == 32'h12345678) wcnt++;
      if (bus.d_valid) begin vcnt++; bus.d_wr = 1'b0; end
    end
    bus.d_wr = 1'b0;
    chk("store_wr_cyc", wcnt, L);
    chk("store_pulses", vcnt, 1);
    chk("store_rdata",  bus.d_rdata, rd_before);

    // Flush in mid ACCESS of a fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h48;
    rdc = 0; vcnt = 0;
    @(negedge clk); if (bus.mem_rd) rdc++;
    @(negedge clk); if (bus.mem_rd) rdc++;
    bus.if_flush = 1'b1; bus.if_req = 1'b0;
    @(negedge clk); if (bus.mem_rd) rdc++; if (bus.if_valid) vcnt++;
    bus.if_flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.mem_rd) rdc++;
      if (bus.if_valid) vcnt++;
    end
    chk("flush_rd_cyc",   rdc, L);
    chk("flush_no_valid", vcnt, 0);
    do_fetch(32'h40, cyc, rdc);
    chk("flush_next_lat",  cyc, L + 1);
    chk("flush_next_inst", bus.if_inst, 32'h8C010004);
    repeat (2) @(negedge clk);

    // Reset during the second ACCESS cycle
    bus.d_rd = 1'b1; bus.d_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstacc_mem_rd",  {31'd0, bus.mem_rd},  32'd0);
    chk("rstacc_d_valid", {31'd0, bus.d_valid}, 32'd0);
    chk("rstacc_state",   {30'd0, dut.state_q}, 32'd0);
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.d_valid) break;
    end
    chk("rstacc_relat", cyc, L + 1);
    chk("rstacc_rdata", bus.d_rdata, 32'hDEADBEEF);
    bus.d_rd = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized traffic
    nvalid = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      if (bus.if_valid || bus.d_valid) nvalid++;
      bus.if_flush = 1'b0;
      if (bus.if_req && bus.if_valid) begin
        r = $urandom;
        bus.if_req = r[0];
        bus.if_addr = {20'd0, r[11:2], 2'b00};
      end else if (!bus.if_req && $urandom_range(0, 3) == 0) begin
        r = $urandom;
        bus.if_req = 1'b1;
        bus.if_addr = {20'd0, r[11:2], 2'b00};
      end
      if (!bus.if_valid && $urandom_range(0, 19) == 0) begin
        r = $urandom;
        bus.if_flush = 1'b1;
        bus.if_req = r[0];
        bus.if_addr = {20'd0, r[11:2], 2'b00};
      end
      if ((bus.d_rd || bus.d_wr) && bus.d_valid) begin
        bus.d_rd = 1'b0; bus.d_wr = 1'b0;
      end else if (!(bus.d_rd || bus.d_wr) && $urandom_range(0, 2) == 0) begin
        r = $urandom;
        case ($urandom_range(0, 2))
          0:       begin bus.d_rd = 1'b1; bus.d_wr = 1'b0; end
          1:       begin bus.d_rd = 1'b0; bus.d_wr = 1'b1; end
          default: begin bus.d_rd = 1'b1; bus.d_wr = 1'b1; end
        endcase
        bus.d_addr  = {20'd0, r[11:2], 2'b00};
        bus.d_wdata = $urandom;
      end
    end
    rst = 1'b0;
    bus.if_req = 0; bus.if_flush = 0; bus.d_rd = 0; bus.d_wr = 0;
    repeat (10) @(negedge clk);
    chk("rand_progress", {31'd0, nvalid > 200}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
